// File: rtl/imem_arb.sv
// imem_arb: single-port instruction memory arbiter between boot loader and fetch, with loader starvation guard
module imem_arb #(
    parameter int DEPTH      = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     f_req,
    input  logic [31:0]              f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [31:0]              f_rdata,
    output logic                     f_err,
    input  logic                     l_req,
    input  logic [31:0]              l_addr,
    input  logic [31:0]              l_wdata,
    input  logic                     l_last,
    output logic                     l_gnt,
    output logic                     l_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic                     boot_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic {BOOT, RUN} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          f_ok, l_ok, force_l, f_mem, l_mem;
    logic [31:0]   rd_q;
    assign f_ok    = f_addr[1:0] == 2'b00 && f_addr < 32'(4 * DEPTH);
    assign l_ok    = l_addr[1:0] == 2'b00 && l_addr < 32'(4 * DEPTH);
    assign force_l = cnt == CW'(STARVE_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = (state == BOOT && l_gnt && l_last) ? RUN : state;
        cnt_nx   = (state == RUN && l_req && !l_gnt) ? cnt + 1'b1 : '0;
    end
    always_comb begin
        f_gnt     = rst_n && state == RUN && f_req && !force_l;
        l_gnt     = rst_n && l_req && (state == BOOT || !f_req || force_l);
        f_mem     = f_gnt && f_ok;
        l_mem     = l_gnt && l_ok;
        mem_en    = f_mem || l_mem;
        mem_we    = l_mem;
        mem_addr  = f_mem ? f_addr[AW+1:2] : l_mem ? l_addr[AW+1:2] : '0;
        mem_wdata = l_mem ? l_wdata : '0;
        boot_done = state == RUN;
        f_rdata   = (f_rvalid && !f_err) ? mem_rdata : rd_q;
    end
    // rd_q keeps the last delivered word so f_rdata holds between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            f_err    <= 1'b0;
            l_err    <= 1'b0;
            rd_q     <= '0;
        end else begin
            f_rvalid <= f_gnt;
            f_err    <= f_gnt && !f_ok;
            l_err    <= l_gnt && !l_ok;
            rd_q     <= (f_gnt && !f_ok) ? '0 : f_rdata;
        end
    end
endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: directed self-checking bench for imem_arb with a synchronous RAM model
module tb_imem_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0, l_req = 1'b0, l_last = 1'b0;
    logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_err, mem_en, mem_we, boot_done;
    logic [31:0] f_rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_addr;
    logic [31:0] ram [0:63];
    int          n_chk = 0, n_err = 0;

    imem_arb #(.DEPTH(64), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err), .l_req(l_req),
        .l_addr(l_addr), .l_wdata(l_wdata), .l_last(l_last), .l_gnt(l_gnt),
        .l_err(l_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .boot_done(boot_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                         input logic [31:0] la, input logic [31:0] ld, input logic ll);
        f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = ld; l_last = ll;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 1, 0, 32'h1, 1);
        chk("rst f_gnt", f_gnt, 0);
        chk("rst l_gnt", l_gnt, 0);
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst f_rvalid", f_rvalid, 0);
        chk("rst f_rdata", f_rdata, 0);
        chk("rst f_err", f_err, 0);
        chk("rst l_err", l_err, 0);
        chk("rst boot_done", boot_done, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        chk("boot_done after rst", boot_done, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk("boot f_gnt", f_gnt, 0);
            chk("boot f mem_en", mem_en, 0);
            tick();
            chk("boot f_rvalid", f_rvalid, 0);
        end
        drive(0, 0, 1, 32'h0, 32'h20080005, 0);
        chk("load0 l_gnt", l_gnt, 1);
        chk("load0 mem_we", mem_we, 1);
        chk("load0 mem_addr", 32'(mem_addr), 0);
        chk("load0 mem_wdata", mem_wdata, 32'h20080005);
        tick();
        chk("load0 boot_done", boot_done, 0);
        drive(1, 0, 1, 32'h4, 32'h20090007, 1);
        chk("load1 l_gnt", l_gnt, 1);
        chk("load1 f_gnt", f_gnt, 0);
        chk("load1 mem_we", mem_we, 1);
        chk("load1 mem_addr", 32'(mem_addr), 1);
        tick();
        chk("load1 boot_done", boot_done, 1);
        chk("load1 l_err", l_err, 0);
        drive(1, 32'h4, 0, 0, 0, 0);
        chk("fetch4 f_gnt", f_gnt, 1);
        chk("fetch4 mem_en", mem_en, 1);
        chk("fetch4 mem_we", mem_we, 0);
        chk("fetch4 mem_addr", 32'(mem_addr), 1);
        tick();
        chk("fetch4 f_rvalid", f_rvalid, 1);
        chk("fetch4 f_rdata", f_rdata, 32'h20090007);
        chk("fetch4 f_err", f_err, 0);
        drive(1, 32'h0, 0, 0, 0, 0);
        tick();
        drive(1, 32'h4, 0, 0, 0, 0);
        chk("b2b0 f_rvalid", f_rvalid, 1);
        chk("b2b0 f_rdata", f_rdata, 32'h20080005);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("b2b1 f_rvalid", f_rvalid, 1);
        chk("b2b1 f_rdata", f_rdata, 32'h20090007);
        tick();
        chk("idle f_rvalid", f_rvalid, 0);
        chk("idle f_rdata hold", f_rdata, 32'h20090007);
        for (int c = 1; c <= 5; c++) begin
            drive(1, 32'h0, 1, 32'h8, 32'hDEADBEEF, 1);
            chk($sformatf("starve c%0d l_gnt", c), l_gnt, c == 5);
            chk($sformatf("starve c%0d f_gnt", c), f_gnt, c != 5);
            if (c == 5) chk("starve mem_addr", 32'(mem_addr), 2);
            tick();
            chk($sformatf("starve c%0d f_rvalid", c), f_rvalid, c != 5);
        end
        drive(1, 32'h0, 1, 32'h8, 32'hDEADBEEF, 1);
        chk("resume f_gnt", f_gnt, 1);
        chk("resume l_gnt", l_gnt, 0);
        tick();
        chk("l_last in RUN", boot_done, 1);
        drive(1, 32'h8, 0, 0, 0, 0);
        tick();
        chk("readback f_rdata", f_rdata, 32'hDEADBEEF);
        drive(1, 32'h2, 0, 0, 0, 0);
        chk("mis f_gnt", f_gnt, 1);
        chk("mis mem_en", mem_en, 0);
        tick();
        chk("mis f_rvalid", f_rvalid, 1);
        chk("mis f_err", f_err, 1);
        chk("mis f_rdata", f_rdata, 0);
        drive(1, 32'h100, 0, 0, 0, 0);
        chk("oor mem_en", mem_en, 0);
        tick();
        chk("oor f_err", f_err, 1);
        drive(1, 32'hFC, 0, 0, 0, 0);
        chk("top mem_en", mem_en, 1);
        chk("top mem_addr", 32'(mem_addr), 63);
        tick();
        chk("top f_err", f_err, 0);
        drive(0, 0, 1, 32'h100, 32'h5, 0);
        chk("lw oor l_gnt", l_gnt, 1);
        chk("lw oor mem_en", mem_en, 0);
        tick();
        chk("lw oor l_err", l_err, 1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("l_err pulse", l_err, 0);
        drive(1, 32'h0, 0, 0, 0, 0);
        chk("pre-rst f_gnt", f_gnt, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst mid f_rvalid", f_rvalid, 0);
        chk("rst mid f_gnt", f_gnt, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 32'h4, 0, 0, 0, 0);
        chk("post-rst f_rvalid", f_rvalid, 0);
        chk("post-rst boot_done", boot_done, 0);
        chk("post-rst f_gnt", f_gnt, 0);
        tick();
        chk("post-rst f_rvalid2", f_rvalid, 0);
        drive(1, 32'h4, 1, 32'hC, 32'h12345678, 1);
        chk("reboot l_gnt", l_gnt, 1);
        chk("reboot f_gnt", f_gnt, 0);
        tick();
        drive(1, 32'h4, 0, 0, 0, 0);
        chk("reboot f_gnt run", f_gnt, 1);
        tick();
        chk("retain f_rdata", f_rdata, 32'h20090007);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
